// File: rtl/simon_key_schedule_serial.sv
// Bit-serial SIMON key schedule: serial master-key load, round keys streamed LSB first.
// Optional feature macro SIMON_KS_REWIND_EN keeps a shadow master key for restart and re-run.
module simon_key_schedule_serial #(
  parameter int unsigned N      = 32,
  parameter int unsigned M      = 4,
  parameter int unsigned ROUNDS = 44,
  parameter logic [61:0] ZSEQ   = 62'b11_1100001011_0011100101_0001001000_0001111010_0110001101_0111011011
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_load,
  input  logic                 key_in,
  input  logic                 start,
  input  logic                 key_ready,
  input  logic                 restart,
  output logic                 key_out,
  output logic                 key_valid,
  output logic [$clog2(N)-1:0] bit_idx,
  output logic [6:0]           round_idx,
  output logic                 round_last_bit,
  output logic                 busy,
  output logic                 key_loaded,
  output logic                 done
);

  localparam int unsigned KW = M * N;
  localparam int unsigned BW = $clog2(N);
  localparam int unsigned CW = $clog2(KW);
  localparam int unsigned LW = (M - 1) * N;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [KW-1:0] ks;
  logic [CW-1:0] load_cnt;
  logic [5:0]    z_idx;
  logic          wrap1, wrap3, wrap4;
  logic          cz, r3, r4, gen_bit;

`ifdef SIMON_KS_REWIND_EN
  logic [KW-1:0] shadow;
`else
  logic unused_restart;
  assign unused_restart = restart;
`endif

  // ks is a sliding window over the key stream: ks[p] is stream bit (i*N + bit_idx + p),
  // so rotate wrap-around bits of the newest word are still present at its low end.
  always_comb begin
    z_idx = (round_idx >= 7'd62) ? 6'(round_idx - 7'd62) : 6'(round_idx);
    wrap1 = (bit_idx == BW'(N - 1));
    wrap3 = (bit_idx >= BW'(N - 3));
    wrap4 = (bit_idx >= BW'(N - 4));
    if (bit_idx == '0)            cz = ZSEQ[z_idx];
    else if (bit_idx == BW'(1))   cz = 1'b0;
    else                          cz = 1'b1;
    r3 = wrap3 ? ks[LW - N + 3] : ks[LW + 3];
    r4 = wrap4 ? ks[LW - N + 4] : ks[LW + 4];
    if (M == 4) gen_bit = cz ^ ks[0] ^ r3 ^ ks[N] ^ r4 ^ (wrap1 ? ks[1] : ks[N + 1]);
    else        gen_bit = cz ^ ks[0] ^ r3 ^ r4;
  end

  assign key_out        = ks[0];
  assign round_last_bit = key_valid && (bit_idx == BW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ks         <= '0;
      load_cnt   <= '0;
      key_valid  <= 1'b0;
      bit_idx    <= '0;
      round_idx  <= '0;
      busy       <= 1'b0;
      key_loaded <= 1'b0;
      done       <= 1'b0;
`ifdef SIMON_KS_REWIND_EN
      shadow     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
`ifdef SIMON_KS_REWIND_EN
          if (state == S_DONE && restart) begin
            ks        <= shadow;
            state     <= S_RUN;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            bit_idx   <= '0;
            round_idx <= '0;
          end else
`endif
          if (key_load) begin
            ks         <= {key_in, ks[KW-1:1]};
`ifdef SIMON_KS_REWIND_EN
            shadow     <= {key_in, shadow[KW-1:1]};
`endif
            load_cnt   <= CW'(1);
            state      <= S_LOAD;
            busy       <= 1'b1;
            key_loaded <= 1'b0;
            done       <= 1'b0;
          end else if (start && key_loaded) begin
`ifdef SIMON_KS_REWIND_EN
            ks        <= shadow;
`endif
            state     <= S_RUN;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            bit_idx   <= '0;
            round_idx <= '0;
          end
        end
        S_LOAD: begin
          if (key_load) begin
            ks <= {key_in, ks[KW-1:1]};
`ifdef SIMON_KS_REWIND_EN
            shadow <= {key_in, shadow[KW-1:1]};
`endif
            if (load_cnt == CW'(KW - 1)) begin
              load_cnt   <= '0;
              state      <= S_IDLE;
              busy       <= 1'b0;
              key_loaded <= 1'b1;
            end else begin
              load_cnt <= load_cnt + CW'(1);
            end
          end
        end
        S_RUN: begin
`ifdef SIMON_KS_REWIND_EN
          if (restart) begin
            ks        <= shadow;
            bit_idx   <= '0;
            round_idx <= '0;
          end else
`endif
          if (key_ready) begin
            ks <= {gen_bit, ks[KW-1:1]};
            if (bit_idx == BW'(N - 1)) begin
              bit_idx <= '0;
              if (round_idx == 7'(ROUNDS - 1)) begin
                state     <= S_DONE;
                key_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                round_idx <= '0;
`ifndef SIMON_KS_REWIND_EN
                key_loaded <= 1'b0;
`endif
              end else begin
                round_idx <= round_idx + 7'd1;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_schedule_serial.sv
// Scoreboard bench for simon_key_schedule_serial: word-level reference model feeds expected
// bit queues; negedge monitors pop and compare on every handshake.
module tb_simon_key_schedule_serial;

  localparam int NA = 32, MA = 4, RA = 44;
  localparam int NB = 16, MB = 2, RB = 32;
  localparam logic [61:0] Z0V = 62'b01_1001110000_1101010010_0010111110_1100111000_0110101001_0001011111;

  string z3s = "11011011101011000110010111100000010010001010011100110100001111";
  string z0s = "11111010001001010110000111001101111101000100101011000011100110";

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_key_load, a_key_in, a_start, a_key_ready, a_restart;
  logic a_key_out, a_key_valid, a_rlb, a_busy, a_key_loaded, a_done;
  logic [4:0] a_bit_idx;
  logic [6:0] a_round_idx;
  logic b_key_load, b_key_in, b_start, b_key_ready, b_restart;
  logic b_key_out, b_key_valid, b_rlb, b_busy, b_key_loaded, b_done;
  logic [3:0] b_bit_idx;
  logic [6:0] b_round_idx;

  simon_key_schedule_serial #(.N(NA), .M(MA), .ROUNDS(RA)) dut_a (
    .clk(clk), .reset(rst_n), .key_load(a_key_load), .key_in(a_key_in), .start(a_start),
    .key_ready(a_key_ready), .restart(a_restart), .key_out(a_key_out), .key_valid(a_key_valid),
    .bit_idx(a_bit_idx), .round_idx(a_round_idx), .round_last_bit(a_rlb), .busy(a_busy),
    .key_loaded(a_key_loaded), .done(a_done));

  simon_key_schedule_serial #(.N(NB), .M(MB), .ROUNDS(RB), .ZSEQ(Z0V)) dut_b (
    .clk(clk), .reset(rst_n), .key_load(b_key_load), .key_in(b_key_in), .start(b_start),
    .key_ready(b_key_ready), .restart(b_restart), .key_out(b_key_out), .key_valid(b_key_valid),
    .bit_idx(b_bit_idx), .round_idx(b_round_idx), .round_last_bit(b_rlb), .busy(b_busy),
    .key_loaded(b_key_loaded), .done(b_done));

  typedef struct {
    logic v;
    int   rnd;
    int   bi;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;
  int hs_a = 0;
  int hs_b = 0;
  logic [63:0] kw[72];
  logic [31:0] obs_a[72];
  logic [15:0] obs_b[72];
  logic [31:0] mk_a[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Word-level SIMON key expansion straight from the recurrence.
  task automatic build(input int n, input int m, input string zs,
                       input logic [63:0] k0, input logic [63:0] k1,
                       input logic [63:0] k2, input logic [63:0] k3);
    logic [63:0] mask, c, z, tmp;
    mask = (64'd1 << n) - 64'd1;
    c = mask ^ 64'd3;
    kw[0] = k0; kw[1] = k1; kw[2] = k2; kw[3] = k3;
    for (int i = 0; i + m < 72; i++) begin
      z = (zs[i % 62] == 8'h31) ? 64'd1 : 64'd0;
      if (m == 4) begin
        tmp = rotr(kw[i+3], 3, n) ^ kw[i+1];
        kw[i+4] = c ^ z ^ kw[i] ^ tmp ^ rotr(tmp, 1, n);
      end else begin
        kw[i+m] = c ^ z ^ kw[i] ^ rotr(kw[i+m-1], 3, n) ^ rotr(kw[i+m-1], 4, n);
      end
    end
  endtask

  task automatic push_a();
    exp_t e;
    for (int r = 0; r < RA; r++)
      for (int b = 0; b < NA; b++) begin
        e.v = kw[r][b]; e.rnd = r; e.bi = b;
        qa.push_back(e);
      end
  endtask

  task automatic push_b();
    exp_t e;
    for (int r = 0; r < RB; r++)
      for (int b = 0; b < NB; b++) begin
        e.v = kw[r][b]; e.rnd = r; e.bi = b;
        qb.push_back(e);
      end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && a_key_valid && a_key_ready && !a_restart) begin
      hs_a++;
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_extra_bit: round %0d bit %0d with nothing expected", a_round_idx, a_bit_idx);
      end else begin
        e = qa.pop_front();
        check("a_key_out", 64'(a_key_out), 64'(e.v));
        check("a_round_idx", 64'(a_round_idx), 64'(e.rnd));
        check("a_bit_idx", 64'(a_bit_idx), 64'(e.bi));
        check("a_round_last_bit", 64'(a_rlb), 64'(e.bi == NA - 1));
        obs_a[e.rnd][e.bi] = a_key_out;
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && b_key_valid && b_key_ready) begin
      hs_b++;
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra_bit: round %0d bit %0d with nothing expected", b_round_idx, b_bit_idx);
      end else begin
        e = qb.pop_front();
        check("b_key_out", 64'(b_key_out), 64'(e.v));
        check("b_round_idx", 64'(b_round_idx), 64'(e.rnd));
        check("b_bit_idx", 64'(b_bit_idx), 64'(e.bi));
        check("b_round_last_bit", 64'(b_rlb), 64'(e.bi == NB - 1));
        obs_b[e.rnd][e.bi] = b_key_out;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a_range(input int from, input int to);
    for (int j = from; j < to; j++) begin
      a_key_load = 1'b1;
      a_key_in = mk_a[j / NA][j % NA];
      tick();
    end
    a_key_load = 1'b0;
  endtask

  task automatic start_a();
    hs_a = 0;
    push_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_valid_after_start", 64'(a_key_valid), 64'd1);
    check("a_round_after_start", 64'(a_round_idx), 64'd0);
  endtask

  // Random backpressure until done; optional rewind when round restart_round is on key_out.
  task automatic run_a(input int pct, input int restart_round);
    int cyc;
    logic did;
    cyc = 0;
    did = 1'b0;
    while (!a_done && cyc < 20000) begin
      if (restart_round >= 0 && !did && a_round_idx == 7'(restart_round)) begin
        a_restart = 1'b1;
        a_key_ready = 1'($urandom_range(0, 1));
        qa.delete();
        push_a();
        hs_a = 0;
        did = 1'b1;
        tick();
        a_restart = 1'b0;
        check("a_restart_round", 64'(a_round_idx), 64'd0);
        check("a_restart_bit", 64'(a_bit_idx), 64'd0);
        check("a_restart_valid", 64'(a_key_valid), 64'd1);
      end else begin
        a_key_ready = ($urandom_range(0, 99) < pct);
        tick();
      end
      cyc++;
    end
    a_key_ready = 1'b0;
    check("a_done_reached", 64'(a_done), 64'd1);
    check("a_valid_in_done", 64'(a_key_valid), 64'd0);
    check("a_busy_in_done", 64'(a_busy), 64'd0);
    check("a_handshakes", 64'(hs_a), 64'(RA * NA));
    check("a_queue_drained", 64'(qa.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    a_key_load = 0; a_key_in = 0; a_start = 0; a_key_ready = 0; a_restart = 0;
    b_key_load = 0; b_key_in = 0; b_start = 0; b_key_ready = 0; b_restart = 0;
    repeat (3) tick();
    check("rst_valid", 64'(a_key_valid), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_loaded", 64'(a_key_loaded), 64'd0);
    check("rst_bit_idx", 64'(a_bit_idx), 64'd0);
    check("rst_round_idx", 64'(a_round_idx), 64'd0);
    check("rst_key_out", 64'(a_key_out), 64'd0);
    check("rst_last_bit", 64'(a_rlb), 64'd0);
    check("rst_b_valid", 64'(b_key_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // N=16, M=2, z0, all-zero key
    for (int j = 0; j < NB * MB; j++) begin
      b_key_load = 1'b1; b_key_in = 1'b0;
      tick();
    end
    b_key_load = 1'b0;
    check("b_loaded", 64'(b_key_loaded), 64'd1);
    build(NB, MB, z0s, 64'd0, 64'd0, 64'd0, 64'd0);
    push_b();
    hs_b = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 5000) begin
      b_key_ready = ($urandom_range(0, 99) < 70);
      tick();
      cyc++;
    end
    b_key_ready = 1'b0;
    check("b_done", 64'(b_done), 64'd1);
    check("b_handshakes", 64'(hs_b), 64'd512);
    check("b_k0", 64'(obs_b[0]), 64'h0);
    check("b_k2", 64'(obs_b[2]), 64'hFFFD);
    check("b_queue_drained", 64'(qb.size()), 64'd0);

    // N=32, M=4, all-zero key
    for (int w = 0; w < 4; w++) mk_a[w] = 32'h0;
    load_a_range(0, NA * MA);
    check("a_loaded_zero", 64'(a_key_loaded), 64'd1);
    check("a_busy_after_load", 64'(a_busy), 64'd0);
    build(NA, MA, z3s, 64'd0, 64'd0, 64'd0, 64'd0);
    start_a();
    run_a(100, -1);
    check("a_zero_k0", 64'(obs_a[0]), 64'h0);
    check("a_zero_k3", 64'(obs_a[3]), 64'h0);
    check("a_zero_k4", 64'(obs_a[4]), 64'hFFFFFFFD);
`ifdef SIMON_KS_REWIND_EN
    check("a_loaded_kept", 64'(a_key_loaded), 64'd1);
`else
    check("a_loaded_cleared", 64'(a_key_loaded), 64'd0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_start_after_done_ignored", 64'(a_key_valid), 64'd0);
    check("a_done_holds", 64'(a_done), 64'd1);
`endif

    // reference key, load paused for 5 cycles with start attempted meanwhile
    mk_a[0] = 32'h03020100; mk_a[1] = 32'h0B0A0908;
    mk_a[2] = 32'h13121110; mk_a[3] = 32'h1B1A1918;
    load_a_range(0, 50);
    repeat (5) begin
      a_start = 1'b1;
      tick();
    end
    a_start = 1'b0;
    check("pause_valid", 64'(a_key_valid), 64'd0);
    check("pause_busy", 64'(a_busy), 64'd1);
    check("pause_loaded", 64'(a_key_loaded), 64'd0);
    check("pause_done_cleared", 64'(a_done), 64'd0);
    load_a_range(50, NA * MA);
    check("a_loaded_ref", 64'(a_key_loaded), 64'd1);
    build(NA, MA, z3s, 64'(mk_a[0]), 64'(mk_a[1]), 64'(mk_a[2]), 64'(mk_a[3]));
    start_a();
`ifdef SIMON_KS_REWIND_EN
    run_a(60, 10);
    start_a();
    run_a(60, -1);
`else
    run_a(60, -1);
`endif
    for (int w = 0; w < 4; w++) check("a_master_word", 64'(obs_a[w]), 64'(mk_a[w]));

    // random key, async reset in round 7
    for (int w = 0; w < 4; w++) mk_a[w] = $urandom;
    load_a_range(0, NA * MA);
    build(NA, MA, z3s, 64'(mk_a[0]), 64'(mk_a[1]), 64'(mk_a[2]), 64'(mk_a[3]));
    start_a();
    cyc = 0;
    while (a_round_idx != 7'd7 && cyc < 5000) begin
      a_key_ready = ($urandom_range(0, 99) < 60);
      tick();
      cyc++;
    end
    check("a_reached_round7", 64'(a_round_idx), 64'd7);
    #2 rst_n = 1'b0;
    a_key_ready = 1'b0;
    #1;
    check("mid_rst_valid", 64'(a_key_valid), 64'd0);
    check("mid_rst_busy", 64'(a_busy), 64'd0);
    check("mid_rst_loaded", 64'(a_key_loaded), 64'd0);
    check("mid_rst_round", 64'(a_round_idx), 64'd0);
    check("mid_rst_bit", 64'(a_bit_idx), 64'd0);
    check("mid_rst_key_out", 64'(a_key_out), 64'd0);
    qa.delete();
    tick();
    rst_n = 1'b1;
    tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("start_unloaded_valid", 64'(a_key_valid), 64'd0);
    check("start_unloaded_busy", 64'(a_busy), 64'd0);
    tick();
    check("start_unloaded_idle", 64'(a_key_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
